// File: rtl/instr_fetch_if.sv
// RAM port-1 read bus between the fetch stage (master) and the instruction RAM (slave).
interface instr_fetch_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] ram_addr1;
    logic [31:0]       ram_rdata1;

    modport master (output ram_addr1, input  ram_rdata1);
    modport slave  (input  ram_addr1, output ram_rdata1);
endinterface

// File: rtl/instr_fetch.sv
// Program counter and instruction-fetch stage: launches RAM reads, buffers the word, loads IR.
// Optional FETCH_PERF_EN adds completed-fetch and busy-cycle counters.
//
// state   | meaning
// --------+------------------------------------------
// S_IDLE  | no fetch in flight, buffer empty
// S_WAIT  | read launched, latency counter running
// S_READY | buffer holds a word not yet moved to IR
module instr_fetch #(
    parameter int                ADDR_W   = 11,
    parameter int                RAM_LAT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_pc,
    input  logic [1:0]        sel_pc,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [31:0]       datapath_pc,
    input  logic              load_ir,
    instr_fetch_if.master     ram,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_seq,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic              P,
    output logic              U,
    output logic              W,
    output logic              ir_err
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       perf_fetches,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] fetch_addr;
    logic [31:0]       fetch_buf;
    logic [ADDR_W-1:0] next_addr;
    logic              wait_tc;
    logic              fetch_complete;

    always_comb begin
        next_addr = pc_seq;
        unique case (sel_pc)
            2'b00: next_addr = pc_seq;
            2'b01: next_addr = branch_target;
            2'b10: next_addr = datapath_pc[ADDR_W-1:0];
            2'b11: next_addr = RESET_PC;
        endcase
    end

    // Terminal count: read data is valid on this cycle's edge.
    assign wait_tc        = (state == S_WAIT) && (lat_cnt == '0);
    // A restart without load_ir throws the arriving word away, so it does not count.
    assign fetch_complete = wait_tc && (load_ir || !load_pc);

    assign cond = instr[31:28];
    assign P    = instr[24];
    assign U    = instr[23];
    assign W    = instr[21];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            lat_cnt       <= '0;
            fetch_addr    <= RESET_PC;
            fetch_buf     <= '0;
            ram.ram_addr1 <= RESET_PC;
            pc            <= RESET_PC;
            pc_seq        <= RESET_PC;
            fetch_busy    <= 1'b0;
            fetch_done    <= 1'b0;
            instr         <= '0;
            ir_err        <= 1'b0;
`ifdef FETCH_PERF_EN
            perf_fetches  <= '0;
            perf_stall    <= '0;
`endif
        end else begin
            if ((state == S_WAIT) && (lat_cnt != '0))
                lat_cnt <= lat_cnt - 1'b1;

            if (load_ir) begin
                if (state == S_READY) begin
                    instr      <= fetch_buf;
                    pc         <= fetch_addr;
                    fetch_done <= 1'b0;
                    state      <= S_IDLE;
                end else if (wait_tc) begin
                    instr      <= ram.ram_rdata1;
                    pc         <= fetch_addr;
                    fetch_busy <= 1'b0;
                    state      <= S_IDLE;
                end else begin
                    ir_err     <= 1'b1;
                end
            end else if (wait_tc && !load_pc) begin
                fetch_buf  <= ram.ram_rdata1;
                fetch_busy <= 1'b0;
                fetch_done <= 1'b1;
                state      <= S_READY;
            end

            // Launch last so a restart overrides whatever the old fetch did above.
            if (load_pc) begin
                ram.ram_addr1 <= next_addr;
                fetch_addr    <= next_addr;
                pc_seq        <= next_addr + 1'b1;
                lat_cnt       <= CNT_W'(RAM_LAT - 1);
                fetch_busy    <= 1'b1;
                fetch_done    <= 1'b0;
                state         <= S_WAIT;
            end

`ifdef FETCH_PERF_EN
            if (fetch_complete)
                perf_fetches <= perf_fetches + 1'b1;
            if (fetch_busy)
                perf_stall   <= perf_stall + 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, sticky-error sequence, random run against a timestamp model.
module tb_instr_fetch;
    localparam int ADDR_W  = 11;
    localparam int RAM_LAT = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_pc;
    logic [1:0]        sel_pc;
    logic [ADDR_W-1:0] branch_target;
    logic [31:0]       datapath_pc;
    logic              load_ir;
    logic [ADDR_W-1:0] pc, pc_seq;
    logic              fetch_busy, fetch_done;
    logic [31:0]       instr;
    logic [3:0]        cond;
    logic              P, U, W, ir_err;
`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetches, perf_stall;
`endif

    instr_fetch_if #(.ADDR_W(ADDR_W)) ram_bus ();

    instr_fetch #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .load_pc(load_pc), .sel_pc(sel_pc),
        .branch_target(branch_target), .datapath_pc(datapath_pc), .load_ir(load_ir),
        .ram(ram_bus), .pc(pc), .pc_seq(pc_seq), .fetch_busy(fetch_busy),
        .fetch_done(fetch_done), .instr(instr), .cond(cond), .P(P), .U(U), .W(W),
        .ir_err(ir_err)
`ifdef FETCH_PERF_EN
       ,.perf_fetches(perf_fetches), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    // Reference model: a fetch is a timestamped launch that completes RAM_LAT edges later.
    int                edge_n = 0;
    int                m_launch = 0;
    bit                m_inflight = 0, m_ready = 0;
    logic [ADDR_W-1:0] m_addr = '0, m_pc = '0, m_seq = '0, m_fa = '0;
    logic [31:0]       m_buf = '0, m_instr = '0;
    logic              m_err = 1'b0;
    logic [31:0]       m_fetches = '0, m_stall = '0;

    task automatic model_edge();
        logic [ADDR_W-1:0] a;
        bit tc, ev, busy_before;
        busy_before = m_inflight;
        ev = 0;
        if (rst) begin
            m_inflight = 0; m_ready = 0;
            m_addr = RESET_PC; m_pc = RESET_PC; m_seq = RESET_PC; m_fa = RESET_PC;
            m_buf = '0; m_instr = '0; m_err = 1'b0;
            m_fetches = '0; m_stall = '0;
        end else begin
            tc = m_inflight && (edge_n - m_launch == RAM_LAT);
            if (load_ir) begin
                if (m_ready) begin
                    m_instr = m_buf; m_pc = m_fa; m_ready = 0;
                end else if (tc) begin
                    m_instr = ram_bus.ram_rdata1; m_pc = m_fa; m_inflight = 0; ev = 1;
                end else begin
                    m_err = 1'b1;
                end
            end else if (tc && !load_pc) begin
                m_buf = ram_bus.ram_rdata1; m_ready = 1; m_inflight = 0; ev = 1;
            end
            if (load_pc) begin
                case (sel_pc)
                    2'b00:   a = m_seq;
                    2'b01:   a = branch_target;
                    2'b10:   a = datapath_pc[ADDR_W-1:0];
                    default: a = RESET_PC;
                endcase
                m_addr = a; m_fa = a; m_seq = a + 11'd1;
                m_inflight = 1; m_ready = 0; m_launch = edge_n;
            end
            if (ev)          m_fetches = m_fetches + 32'd1;
            if (busy_before) m_stall   = m_stall + 32'd1;
        end
        edge_n++;
    endtask

    task automatic drive(logic r, logic lp, logic [1:0] s, logic [ADDR_W-1:0] bt,
                         logic [31:0] dp, logic li, logic [31:0] rd);
        rst = r; load_pc = lp; sel_pc = s; branch_target = bt;
        datapath_pc = dp; load_ir = li; ram_bus.ram_rdata1 = rd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(int idx);
        chk("addr",  idx, 32'(ram_bus.ram_addr1), 32'(m_addr));
        chk("pc",    idx, 32'(pc),         32'(m_pc));
        chk("seq",   idx, 32'(pc_seq),     32'(m_seq));
        chk("busy",  idx, 32'(fetch_busy), 32'(m_inflight));
        chk("done",  idx, 32'(fetch_done), 32'(m_ready));
        chk("err",   idx, 32'(ir_err),     32'(m_err));
        chk("instr", idx, instr,           m_instr);
        chk("fields", idx, {24'd0, cond, P, U, W, 1'b0},
            {24'd0, m_instr[31:28], m_instr[24], m_instr[23], m_instr[21], 1'b0});
`ifdef FETCH_PERF_EN
        chk("perf_fetches", idx, perf_fetches, m_fetches);
        chk("perf_stall",   idx, perf_stall,   m_stall);
`endif
    endtask

    typedef struct {
        logic              r, lp;
        logic [1:0]        s;
        logic [ADDR_W-1:0] bt;
        logic [31:0]       dp;
        logic              li;
        logic [31:0]       rd;
        logic [ADDR_W-1:0] ea, ep, es;
        logic              eb, ed, ee;
        logic [31:0]       ei;
    } vec_t;

    function automatic vec_t v(logic r, logic lp, logic [1:0] s, logic [ADDR_W-1:0] bt,
                               logic [31:0] dp, logic li, logic [31:0] rd,
                               logic [ADDR_W-1:0] ea, logic [ADDR_W-1:0] ep,
                               logic [ADDR_W-1:0] es, logic eb, logic ed, logic ee,
                               logic [31:0] ei);
        vec_t t;
        t.r = r; t.lp = lp; t.s = s; t.bt = bt; t.dp = dp; t.li = li; t.rd = rd;
        t.ea = ea; t.ep = ep; t.es = es; t.eb = eb; t.ed = ed; t.ee = ee; t.ei = ei;
        return t;
    endfunction

    vec_t vt[23];

    initial begin
        // inputs: rst lp sel bt dp li rdata | expected after edge: addr pc seq busy done err instr
        vt[0]  = v(1'b1,1'b0,2'd0,11'h000,32'h0,1'b0,32'h0,        11'h000,11'h000,11'h000,1'b0,1'b0,1'b0,32'h0);
        vt[1]  = v(1'b0,1'b1,2'd0,11'h000,32'h0,1'b0,32'h0,        11'h000,11'h000,11'h001,1'b1,1'b0,1'b0,32'h0);
        vt[2]  = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'hDEADBEEF, 11'h000,11'h000,11'h001,1'b1,1'b0,1'b0,32'h0);
        vt[3]  = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'hE3A01005, 11'h000,11'h000,11'h001,1'b0,1'b1,1'b0,32'h0);
        vt[4]  = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b1,32'h0,        11'h000,11'h000,11'h001,1'b0,1'b0,1'b0,32'hE3A01005);
        vt[5]  = v(1'b0,1'b1,2'd1,11'h7FF,32'h0,1'b0,32'h0,        11'h7FF,11'h000,11'h000,1'b1,1'b0,1'b0,32'hE3A01005);
        vt[6]  = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'h0,        11'h7FF,11'h000,11'h000,1'b1,1'b0,1'b0,32'hE3A01005);
        vt[7]  = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'hAAAA0001, 11'h7FF,11'h000,11'h000,1'b0,1'b1,1'b0,32'hE3A01005);
        vt[8]  = v(1'b0,1'b1,2'd0,11'h000,32'h0,1'b1,32'h0,        11'h000,11'h7FF,11'h001,1'b1,1'b0,1'b0,32'hAAAA0001);
        vt[9]  = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'h0,        11'h000,11'h7FF,11'h001,1'b1,1'b0,1'b0,32'hAAAA0001);
        vt[10] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b1,32'h12345678, 11'h000,11'h000,11'h001,1'b0,1'b0,1'b0,32'h12345678);
        vt[11] = v(1'b0,1'b1,2'd0,11'h000,32'h0,1'b0,32'h0,        11'h001,11'h000,11'h002,1'b1,1'b0,1'b0,32'h12345678);
        vt[12] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b1,32'h0,        11'h001,11'h000,11'h002,1'b1,1'b0,1'b1,32'h12345678);
        vt[13] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'h00000055, 11'h001,11'h000,11'h002,1'b0,1'b1,1'b1,32'h12345678);
        vt[14] = v(1'b0,1'b1,2'd0,11'h000,32'h0,1'b0,32'h0,        11'h002,11'h000,11'h003,1'b1,1'b0,1'b1,32'h12345678);
        vt[15] = v(1'b0,1'b1,2'd2,11'h000,32'hFFFFF040,1'b0,32'h0, 11'h040,11'h000,11'h041,1'b1,1'b0,1'b1,32'h12345678);
        vt[16] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'h00000111, 11'h040,11'h000,11'h041,1'b1,1'b0,1'b1,32'h12345678);
        vt[17] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'h40404040, 11'h040,11'h000,11'h041,1'b0,1'b1,1'b1,32'h12345678);
        vt[18] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b1,32'h0,        11'h040,11'h040,11'h041,1'b0,1'b0,1'b1,32'h40404040);
        vt[19] = v(1'b0,1'b1,2'd3,11'h555,32'h123,1'b0,32'h0,      11'h000,11'h040,11'h001,1'b1,1'b0,1'b1,32'h40404040);
        vt[20] = v(1'b1,1'b0,2'd0,11'h000,32'h0,1'b0,32'hFFFFFFFF, 11'h000,11'h000,11'h000,1'b0,1'b0,1'b0,32'h0);
        vt[21] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b0,32'hFFFFFFFF, 11'h000,11'h000,11'h000,1'b0,1'b0,1'b0,32'h0);
        vt[22] = v(1'b0,1'b0,2'd0,11'h000,32'h0,1'b1,32'h0,        11'h000,11'h000,11'h000,1'b0,1'b0,1'b1,32'h0);

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].r, vt[i].lp, vt[i].s, vt[i].bt, vt[i].dp, vt[i].li, vt[i].rd);
            chk("tbl_addr",  i, 32'(ram_bus.ram_addr1), 32'(vt[i].ea));
            chk("tbl_pc",    i, 32'(pc),         32'(vt[i].ep));
            chk("tbl_seq",   i, 32'(pc_seq),     32'(vt[i].es));
            chk("tbl_busy",  i, 32'(fetch_busy), 32'(vt[i].eb));
            chk("tbl_done",  i, 32'(fetch_done), 32'(vt[i].ed));
            chk("tbl_err",   i, 32'(ir_err),     32'(vt[i].ee));
            chk("tbl_instr", i, instr,           vt[i].ei);
            chk("tbl_cond",  i, 32'(cond),       32'(vt[i].ei[31:28]));
        end

        // ir_err is set from the last table row; it must survive fetch activity until reset.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'(i % 3 == 0), 2'(i), 11'(i * 37), 32'(i * 5), 1'(i % 2),
                  32'($urandom));
            chk("sticky_err", i, 32'(ir_err), 32'd1);
            check_model(100 + i);
        end
        drive(1'b1, 1'b0, 2'd0, 11'h0, 32'h0, 1'b0, 32'h0);
        chk("err_cleared", 0, 32'(ir_err), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 149) == 0),
                  1'($urandom_range(0, 99) < 25),
                  2'($urandom_range(0, 3)),
                  11'($urandom),
                  $urandom,
                  1'($urandom_range(0, 99) < 30),
                  $urandom);
            check_model(1000 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
